// File: rtl/xcvr_seq_pkg.sv
// Shared types and constants for the transceiver reset sequencer and its CSR port.
// Status bit layout: [0] tx_pll_locked, [1] rx_is_lockedtoref, [4]/[8] tx/rx reset ack, [5]/[9] tx/rx ready.
package xcvr_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ASSERT_WR,
        ST_HOLD_ACK,
        ST_ACK_RD,
        ST_ACK_CHK,
        ST_HOLD,
        ST_RELEASE_WR,
        ST_WAIT_RDY,
        ST_READY_RD,
        ST_READY_CHK,
        ST_LINK_UP,
        ST_MON_RD,
        ST_MON_CHK,
        ST_RETRY,
        ST_FAIL_WR,
        ST_FAIL
    } seq_state_e;

    localparam logic [3:0]  CTRL_ADDR    = 4'd0;
    localparam logic [3:0]  STAT_ADDR    = 4'd1;
    localparam logic [31:0] CTRL_ASSERT  = 32'h3;
    localparam logic [31:0] CTRL_RELEASE = 32'h0;
    localparam logic [31:0] ACK_MASK     = 32'h110;
    localparam logic [31:0] READY_MASK   = 32'h223;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } csr_req_t;

    function automatic logic mask_set(input logic [31:0] data, input logic [31:0] mask);
        return (data & mask) == mask;
    endfunction

endpackage

// File: rtl/xcvr_csr_master_port.sv
// Avalon-MM master port: turns a one-cycle request into registered one-cycle strobes
// and hands read data back with rd_valid in the cycle after csr_read.
module xcvr_csr_master_port
    import xcvr_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  csr_req_t    req,
    output logic [3:0]  csr_address,
    output logic        csr_read,
    output logic        csr_write,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata,
    output logic        rd_valid,
    output logic [31:0] rd_data
);

    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        rd_valid_q, rd_valid_d;
    logic [3:0]  address_q, address_d;
    logic [31:0] writedata_q, writedata_d;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        write_d     = req.wr;
        read_d      = req.rd && !req.wr;   // a write always wins; the strobes can never overlap
        address_d   = address_q;
        writedata_d = writedata_q;
        rd_valid_d  = read_q;
        if (write_d || read_d) begin
            address_d = req.addr;
        end
        if (write_d) begin
            writedata_d = req.data;
        end
    end

    // NOTE: reset is synchronous, so it is simply the highest-priority branch of the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            read_q      <= read_d;
            write_q     <= write_d;
            rd_valid_q  <= rd_valid_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
        end
    end

    assign csr_address   = address_q;
    assign csr_read      = read_q;
    assign csr_write     = write_q;
    assign csr_writedata = writedata_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = csr_readdata;

endmodule

// File: rtl/xcvr_reset_sequencer.sv
// Brings a transceiver link up through its ctrl/status CSR pair, then watches it and
// re-runs the bring-up on loss of ready, with bounded retries before a sticky error.
module xcvr_reset_sequencer
    import xcvr_seq_pkg::*;
#(
    parameter int HOLD_CYCLES   = 64,
    parameter int POLL_INTERVAL = 16,
    parameter int TIMEOUT_POLLS = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int AUTO_START    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  csr_address,
    output logic        csr_read,
    output logic        csr_write,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata,
    output logic        busy,
    output logic        link_up,
    output logic        error,
    output logic [3:0]  retry_count,
    output logic [11:0] status_snap
);

    localparam int WAIT_MAX = (HOLD_CYCLES > POLL_INTERVAL) ? HOLD_CYCLES : POLL_INTERVAL;
    localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;
    localparam int POLL_W   = $clog2(TIMEOUT_POLLS) + 1;

    seq_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [POLL_W-1:0] poll_q, poll_d, poll_inc;
    logic [3:0]        retry_q, retry_d;
    logic              error_q, error_d;
    logic [11:0]       snap_q, snap_d;
    logic              started_q, started_d;
    logic              busy_q, busy_d;
    logic              link_up_q, link_up_d;
    csr_req_t          req;
    logic              rd_valid;
    logic [31:0]       rd_data;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        poll_d    = poll_q;
        retry_d   = retry_q;
        error_d   = error_q;
        snap_d    = snap_q;
        started_d = 1'b1;
        poll_inc  = (poll_q == POLL_W'(TIMEOUT_POLLS)) ? poll_q : poll_q + POLL_W'(1);

        if (rd_valid) begin
            snap_d = rd_data[11:0];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start || (AUTO_START != 0 && !started_q)) begin
                    state_d = ST_ASSERT_WR;
                    retry_d = '0;
                    error_d = 1'b0;
                end
            end
            ST_ASSERT_WR: begin
                state_d = ST_HOLD_ACK;
                wait_d  = '0;
                poll_d  = '0;
            end
            ST_HOLD_ACK: begin
                if (wait_q == WAIT_W'(POLL_INTERVAL - 1)) state_d = ST_ACK_RD;
                else                                      wait_d  = wait_q + WAIT_W'(1);
            end
            ST_ACK_RD: state_d = ST_ACK_CHK;
            ST_ACK_CHK: begin
                wait_d = '0;
                if (rd_valid && mask_set(rd_data, ACK_MASK)) begin
                    state_d = ST_HOLD;
                end else begin
                    poll_d  = poll_inc;
                    state_d = (poll_inc == POLL_W'(TIMEOUT_POLLS)) ? ST_RETRY : ST_HOLD_ACK;
                end
            end
            ST_HOLD: begin
                if (wait_q == WAIT_W'(HOLD_CYCLES - 1)) state_d = ST_RELEASE_WR;
                else                                    wait_d  = wait_q + WAIT_W'(1);
            end
            ST_RELEASE_WR: begin
                state_d = ST_WAIT_RDY;
                wait_d  = '0;
                poll_d  = '0;
            end
            ST_WAIT_RDY: begin
                if (wait_q == WAIT_W'(POLL_INTERVAL - 1)) state_d = ST_READY_RD;
                else                                      wait_d  = wait_q + WAIT_W'(1);
            end
            ST_READY_RD: state_d = ST_READY_CHK;
            ST_READY_CHK: begin
                wait_d = '0;
                if (rd_valid && mask_set(rd_data, READY_MASK)) begin
                    state_d = ST_LINK_UP;
                    retry_d = '0;
                end else begin
                    poll_d  = poll_inc;
                    state_d = (poll_inc == POLL_W'(TIMEOUT_POLLS)) ? ST_RETRY : ST_WAIT_RDY;
                end
            end
            ST_LINK_UP: begin
                if (wait_q == WAIT_W'(POLL_INTERVAL - 1)) state_d = ST_MON_RD;
                else                                      wait_d  = wait_q + WAIT_W'(1);
            end
            ST_MON_RD: state_d = ST_MON_CHK;
            ST_MON_CHK: begin
                wait_d  = '0;
                state_d = (rd_valid && mask_set(rd_data, READY_MASK)) ? ST_LINK_UP : ST_RETRY;
            end
            ST_RETRY: begin
                if (retry_q == 4'(MAX_RETRIES)) begin
                    state_d = ST_FAIL_WR;
                    error_d = 1'b1;
                end else begin
                    state_d = ST_ASSERT_WR;
                    retry_d = retry_q + 4'd1;
                end
            end
            ST_FAIL_WR: state_d = ST_FAIL;
            ST_FAIL: begin
                if (start) begin
                    state_d = ST_ASSERT_WR;
                    retry_d = '0;
                    error_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Requests and status flags decode the next state so the registered strobes line up
    // with the *_WR / *_RD states themselves; monitor and FAIL_WR are substates of LINK_UP and FAIL.
    always_comb begin
        req       = '0;
        req.rd    = state_d inside {ST_ACK_RD, ST_READY_RD, ST_MON_RD};
        req.wr    = state_d inside {ST_ASSERT_WR, ST_RELEASE_WR, ST_FAIL_WR};
        req.addr  = req.wr ? CTRL_ADDR : STAT_ADDR;
        req.data  = (state_d == ST_RELEASE_WR) ? CTRL_RELEASE : CTRL_ASSERT;
        busy_d    = !(state_d inside {ST_IDLE, ST_LINK_UP, ST_MON_RD, ST_MON_CHK, ST_FAIL_WR, ST_FAIL});
        link_up_d = state_d inside {ST_LINK_UP, ST_MON_RD, ST_MON_CHK};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            poll_q    <= '0;
            retry_q   <= '0;
            error_q   <= 1'b0;
            snap_q    <= '0;
            started_q <= 1'b0;
            busy_q    <= 1'b0;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            poll_q    <= poll_d;
            retry_q   <= retry_d;
            error_q   <= error_d;
            snap_q    <= snap_d;
            started_q <= started_d;
            busy_q    <= busy_d;
            link_up_q <= link_up_d;
        end
    end

    xcvr_csr_master_port u_port (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data)
    );

    assign busy        = busy_q;
    assign link_up     = link_up_q;
    assign error       = error_q;
    assign retry_count = retry_q;
    assign status_snap = snap_q;

endmodule
